inst_sram_responder: RTL and testbench

Responder side of the instruction-fetch memory interface. It accepts fetch requests, reads a word-addressed instruction array, and returns instruction words in order after a fixed latency. Returned words are held stable until the fetch side consumes them. The block sits between the PC/fetch logic and the instruction store and replaces a zero-latency SRAM with a bounded-outstanding request/response slave. A separate preload port fills the array before and during simulation.

---
 rtl/inst_sram_responder.sv | 118 +++++++++++
 tb/tb_inst_sram_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_responder.sv
// Instruction-fetch SRAM responder: word array behind an in-order, fixed-latency response queue.
// Optional feature: define INST_SRAM_MISALIGN_ERR_EN to flag misaligned fetches with inst_err.
module inst_sram_responder #(
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [31:0]           inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [31:0]           inst_rdata,
    output logic                  inst_err,
    input  logic                  inst_rready,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_wdata
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [1:0]    TIMER_INIT = 2'(LATENCY - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(MAX_OUTSTANDING);

    logic [31:0]     r_mem       [2**ADDR_WIDTH];
    logic [31:0]     r_ent_data  [MAX_OUTSTANDING];
    logic            r_ent_err   [MAX_OUTSTANDING];
    logic [1:0]      r_ent_timer [MAX_OUTSTANDING];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_last_data;
    logic            r_last_err;

    logic [ADDR_WIDTH-1:0] w_index;
    logic [31:0]           w_mem_rdata;
    logic [31:0]           w_new_data;
    logic                  w_new_err;
    logic                  w_accept;
    logic                  w_consume;
    logic                  w_head_ready;
    logic                  w_unused_addr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_index       = inst_addr[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^{inst_addr[31:ADDR_WIDTH+2], inst_addr[1:0]};
    assign w_mem_rdata   = r_mem[w_index];

`ifdef INST_SRAM_MISALIGN_ERR_EN
    assign w_new_err  = |inst_addr[1:0];
    assign w_new_data = w_new_err ? 32'h0 : w_mem_rdata;
`else
    assign w_new_err  = 1'b0;
    assign w_new_data = w_mem_rdata;
`endif

    // Acceptance depends only on registered occupancy, never on inst_rready.
    assign inst_addr_ok = resetn && (r_count < COUNT_FULL);
    assign w_head_ready = (r_count != '0) && (r_ent_timer[r_head] == 2'd0);
    assign inst_data_ok = w_head_ready;
    assign inst_rdata   = (r_count != '0) ? r_ent_data[r_head] : r_last_data;
    assign inst_err     = (r_count != '0) ? r_ent_err[r_head]  : r_last_err;

    assign w_accept  = inst_req && inst_addr_ok;
    assign w_consume = w_head_ready && inst_rready;

    // Instruction store is deliberately not reset; preload writes are independent of fetches.
    always_ff @(posedge clk) begin
        if (load_we) begin
            r_mem[load_addr] <= load_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                r_ent_data[i]  <= 32'h0;
                r_ent_err[i]   <= 1'b0;
                r_ent_timer[i] <= 2'd0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_last_data <= 32'h0;
            r_last_err  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if (r_ent_timer[i] != 2'd0) begin
                    r_ent_timer[i] <= r_ent_timer[i] - 2'd1;
                end
            end
            // Later assignment to the tail timer overrides the decrement above.
            if (w_accept) begin
                r_ent_data[r_tail]  <= w_new_data;
                r_ent_err[r_tail]   <= w_new_err;
                r_ent_timer[r_tail] <= TIMER_INIT;
                r_tail              <= ptr_next(r_tail);
            end
            if (w_consume) begin
                r_last_data <= r_ent_data[r_head];
                r_last_err  <= r_ent_err[r_head];
                r_head      <= ptr_next(r_head);
            end
            if (w_accept && !w_consume) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_consume) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder: directed scenarios plus randomized traffic
// checked against a transaction-level queue model.
module tb_inst_sram_responder;

    localparam int unsigned AW   = 12;
    localparam int unsigned LAT  = 1;
    localparam int unsigned MAXO = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inst_req;
    logic [31:0]   inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [31:0]   inst_rdata;
    logic          inst_err;
    logic          inst_rready;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    inst_sram_responder #(
        .ADDR_WIDTH      (AW),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_err     (inst_err),
        .inst_rready  (inst_rready),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_wdata   (load_wdata)
    );

    always #5 clk = ~clk;

    // Transaction model: each accepted fetch becomes a queue entry that is ready at a cycle number.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          rdy;
    } ent_t;

    logic [31:0] m_mem [2**AW];
    ent_t        m_q[$];
    int          cyc = 0;

    function automatic bit exp_addr_ok();
        return (resetn === 1'b1) && (m_q.size() < int'(MAXO));
    endfunction

    function automatic bit exp_data_ok();
        return (m_q.size() > 0) && (m_q[0].rdy <= cyc);
    endfunction

    // Advance one clock edge, updating the model from the inputs seen just before the edge.
    task automatic tick();
        bit          acc;
        bit          cons;
        ent_t        e;
        logic [11:0] idx;
        acc  = inst_req && exp_addr_ok();
        cons = inst_rready && exp_data_ok();
        idx  = inst_addr[13:2];
`ifdef INST_SRAM_MISALIGN_ERR_EN
        e.err  = (inst_addr[1:0] != 2'b00);
        e.data = e.err ? 32'h0 : m_mem[idx];
`else
        e.err  = 1'b0;
        e.data = m_mem[idx];
`endif
        e.rdy = cyc + int'(LAT);
        @(posedge clk);
        if (cons) void'(m_q.pop_front());
        if (acc) m_q.push_back(e);
        if (load_we) m_mem[load_addr] = load_wdata;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0; inst_rready = 1'b0;
        load_we = 1'b0; load_addr = '0; load_wdata = 32'h0;
        tick();
        for (int i = 0; i < 64; i++) begin
            load_we = 1'b1;
            load_addr = AW'(i);
            load_wdata = (i == 0) ? 32'h3c1d_0001 : $urandom;
            tick();
        end
        load_we = 1'b0;
        n_tests++;
        if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok got %b want 0", inst_addr_ok); end
        n_tests++;
        if (inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok got %b want 0", inst_data_ok); end
        n_tests++;
        if (inst_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", inst_rdata); end
        n_tests++;
        if (inst_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", inst_err); end
    endtask

    task automatic test_first_fetch();
        resetn = 1'b1; inst_req = 1'b1; inst_addr = 32'hbfc0_0000; inst_rready = 1'b1;
        #1;
        n_tests++;
        if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL first_addr_ok got %b want 1", inst_addr_ok); end
        tick();
        inst_req = 1'b0;
        n_tests++;
        if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL first_data_ok got %b want 1", inst_data_ok); end
        n_tests++;
        if (inst_rdata !== 32'h3c1d_0001) begin
            n_fail++; $display("FAIL first_rdata got %h want 3c1d0001", inst_rdata);
        end
        tick();
        n_tests++;
        if (inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL first_drained got %b want 0", inst_data_ok); end
    endtask

    task automatic test_stream();
        inst_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_req = 1'b1;
            inst_addr = 32'(i * 4);
            #1;
            n_tests++;
            if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL stream_addr_ok[%0d] got %b want 1", i, inst_addr_ok); end
            if (i > 0) begin
                n_tests++;
                if (inst_data_ok !== 1'b1 || inst_rdata !== m_mem[i-1]) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d] got ok=%b %h want ok=1 %h", i-1, inst_data_ok, inst_rdata, m_mem[i-1]);
                end
            end
            tick();
        end
        inst_req = 1'b0;
        n_tests++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== m_mem[3]) begin
            n_fail++; $display("FAIL stream_data[3] got ok=%b %h want ok=1 %h", inst_data_ok, inst_rdata, m_mem[3]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        inst_rready = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h28; tick();
        inst_addr = 32'h2c; tick();
        inst_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) inst_rready = 1'b1;
            #1;
            n_tests++;
            if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL full_addr_ok[%0d] got %b want 0", k, inst_addr_ok); end
            n_tests++;
            if (inst_data_ok !== 1'b1 || inst_rdata !== m_mem[10]) begin
                n_fail++; $display("FAIL hold_data[%0d] got ok=%b %h want ok=1 %h", k, inst_data_ok, inst_rdata, m_mem[10]);
            end
            tick();
        end
        inst_rready = 1'b0;
        n_tests++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== m_mem[11]) begin
            n_fail++; $display("FAIL second_data got ok=%b %h want ok=1 %h", inst_data_ok, inst_rdata, m_mem[11]);
        end
        n_tests++;
        if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL reopen_addr_ok got %b want 1", inst_addr_ok); end
        inst_rready = 1'b1;
        tick();
    endtask

    task automatic test_same_edge_load();
        logic [31:0] old_word;
        old_word = m_mem[5];
        inst_rready = 1'b1; inst_req = 1'b1; inst_addr = 32'h14;
        load_we = 1'b1; load_addr = AW'(5); load_wdata = 32'hdead_beef;
        tick();
        load_we = 1'b0;
        n_tests++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== old_word) begin
            n_fail++; $display("FAIL same_edge_old got ok=%b %h want ok=1 %h", inst_data_ok, inst_rdata, old_word);
        end
        tick();
        inst_req = 1'b0;
        n_tests++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hdead_beef) begin
            n_fail++; $display("FAIL same_edge_new got ok=%b %h want ok=1 deadbeef", inst_data_ok, inst_rdata);
        end
        tick();
    endtask

    task automatic test_misalign();
        inst_rready = 1'b1; inst_req = 1'b1; inst_addr = 32'hbfc0_0002;
        tick();
        inst_req = 1'b0;
        n_tests++;
`ifdef INST_SRAM_MISALIGN_ERR_EN
        if (inst_data_ok !== 1'b1 || inst_err !== 1'b1 || inst_rdata !== 32'h0) begin
            n_fail++; $display("FAIL misalign got ok=%b err=%b %h want ok=1 err=1 0", inst_data_ok, inst_err, inst_rdata);
        end
`else
        if (inst_data_ok !== 1'b1 || inst_err !== 1'b0 || inst_rdata !== 32'h3c1d_0001) begin
            n_fail++; $display("FAIL misalign got ok=%b err=%b %h want ok=1 err=0 3c1d0001", inst_data_ok, inst_err, inst_rdata);
        end
`endif
        tick();
    endtask

    task automatic test_reset_midop();
        inst_rready = 1'b0; inst_req = 1'b1; inst_addr = 32'h0;
        tick(); tick();
        inst_req = 1'b0;
        n_tests++;
        if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL pending_before_reset got %b want 1", inst_data_ok); end
        #2;
        resetn = 1'b0;
        m_q.delete();
        #1;
        n_tests++;
        if (inst_data_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got data_ok=%b addr_ok=%b want 0 0", inst_data_ok, inst_addr_ok);
        end
        tick();
        resetn = 1'b1;
        inst_rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (inst_data_ok !== 1'b0 || inst_addr_ok !== 1'b1) begin
                n_fail++; $display("FAIL post_reset[%0d] got data_ok=%b addr_ok=%b want 0 1", k, inst_data_ok, inst_addr_ok);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            a[13:2] = 12'($urandom_range(0, 63));
            inst_addr   = a;
            inst_req    = ($urandom_range(0, 3) != 0);
            inst_rready = ($urandom_range(0, 2) != 0);
            load_we     = ($urandom_range(0, 4) == 0);
            load_addr   = AW'($urandom_range(0, 63));
            load_wdata  = $urandom;
            #1;
            n_tests++;
            if (inst_addr_ok !== exp_addr_ok()) begin
                n_fail++; $display("FAIL rand_addr_ok cyc=%0d got %b want %b", cyc, inst_addr_ok, exp_addr_ok());
            end
            n_tests++;
            if (inst_data_ok !== exp_data_ok()) begin
                n_fail++; $display("FAIL rand_data_ok cyc=%0d got %b want %b", cyc, inst_data_ok, exp_data_ok());
            end
            if (exp_data_ok()) begin
                n_tests++;
                if (inst_rdata !== m_q[0].data || inst_err !== m_q[0].err) begin
                    n_fail++;
                    $display("FAIL rand_resp cyc=%0d got %h err=%b want %h err=%b", cyc, inst_rdata, inst_err,
                             m_q[0].data, m_q[0].err);
                end
            end
            tick();
        end
        inst_req = 1'b0; load_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stream();
        test_backpressure();
        test_same_edge_load();
        test_misalign();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
